ocra1_word_buffer: RTL and testbench
====================================

# ocra1_word_buffer

Elastic buffer between the processor-side gradient word source and `ocra1_iface`. It accepts 32-bit OCRA1 command words at any rate, holds them until a complete update group is present, and releases each group as a contiguous burst with one word per clock. The burst is issued only while the interface is idle, so `ocra1_iface` never raises `data_lost_o` in normal operation.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 words (16).
- `HOLDOFF`, default 2: minimum number of idle clocks after a burst's terminator before the next launch decision. Covers `busy_o` latency in `ocra1_iface`.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `data_i`  in  32  command word. Format: [31:27] zero, [26:25] channel, [24] update/terminator, [23:0] DAC payload.
- `valid_i`  in  1  write strobe; one word per cycle.
- `ready_o`  out  1  high when FIFO not full.
- `flush_i`  in  1  synchronous clear of the FIFO and sequencing state.
- `busy_i`  in  1  connects to `ocra1_iface.busy_o`.
- `data_o`  out  32  connects to `ocra1_iface.data_i`.
- `valid_o`  out  1  connects to `ocra1_iface.valid_i`.
- `fill_o`  out  DEPTH_LOG2+1  current word count.
- `groups_o`  out  DEPTH_LOG2+1  number of complete groups (stored terminators) in the FIFO.
- `overflow_o`  out  1  sticky; set when a write is dropped because the FIFO is full.

## Operation
- **Write path**
  - A write is accepted when `valid_i` is high, the FIFO is not full (fill < 2^DEPTH_LOG2 at the start of the cycle) and `flush_i` is low.
  - There is no same-cycle pass-through. A pop in the same cycle does not free space for that cycle's write.
  - A write presented while the FIFO is full is dropped and sets `overflow_o`. Only `rst` clears `overflow_o`.
- **Group counter**
  - Increments when an accepted word has bit24=1.
  - Decrements when a popped word has bit24=1.
  - Simultaneous increment and decrement leave it unchanged.
- **FSM `IDLE` → `BURST` → `IDLE`**
  - `IDLE`: the block launches when groups_o>0, the holdoff counter is 0 and `busy_i` is 0. On launch it pops the head into the `data_o` register and sets `valid_o`=1.
    - If the popped word is a terminator, the state stays `IDLE` and the holdoff counter loads HOLDOFF.
    - Otherwise the state moves to `BURST`.
  - `BURST`: pops one word per cycle into `data_o` with `valid_o`=1. On popping a terminator, the state returns to `IDLE` and the holdoff counter loads HOLDOFF.
  - `busy_i` is ignored inside `BURST`.
  - The FIFO cannot be empty in `BURST`, because a stored terminator guarantees data.
- **Idle output**: when not popping, `valid_o`=0 and `data_o` holds its last value.
- **Holdoff counter**: decrements to 0, one step per cycle.
- **Unterminated data**: words without a terminator remain buffered indefinitely. If the FIFO fills with no terminator, only `flush_i` or `rst` recovers it.
- **`flush_i`**
  - Clears: fill, groups, head/tail pointers, holdoff counter and `valid_o`; state returns to `IDLE`.
  - Does not clear `overflow_o`.
  - If asserted mid-burst, the burst is truncated and the partial group stays as sent.
  - A write in the same cycle as `flush_i` is discarded and does not set overflow.

## Timing
- **Reset values**: `valid_o`=0, `data_o`=0, `fill_o`=0, `groups_o`=0, `overflow_o`=0, state `IDLE`, holdoff counter 0.
- **`ready_o`** is combinational from fill. It reads 0 while `rst` is high and 1 in the first cycle after reset.
- **Launch latency**: terminator written in cycle t (empty FIFO, `busy_i`=0) → groups_o=1 in cycle t+1 → first word on `valid_o` in cycle t+2.
- **Burst shape**: a group of N words gives exactly N consecutive `valid_o` cycles, in write order.
- **Back-to-back groups**: at least HOLDOFF cycles with `valid_o`=0 between bursts, plus as long as `busy_i` stays high.
- **Reset mid-burst**: `valid_o`=0 from the cycle after `rst`, and all buffered words are lost.

## Structure
- **Shared package `ocra1_pkg`**: `OCRA1_WORD_W`=32, `OCRA1_CH_LSB`=25, `OCRA1_CH_W`=2, `OCRA1_UPD_BIT`=24, `OCRA1_PAYLOAD_W`=24, and FSM state constants. `ocra1_iface` reuses the same field constants.
- **Sub-module `ocra1_sync_fifo`**: parameterised synchronous FIFO providing push/pop, flush, full, empty, fill and a combinational head word.
- **Top level**: the FSM, group counter, holdoff counter and output register live in `ocra1_word_buffer`.

## Test plan
- **Reset**: hold `rst` for 3 cycles → `valid_o`=0, `data_o`=0, `fill_o`=0, `overflow_o`=0; `ready_o`=1 after release.
- **Single group**: write 0x00100004, 0x02100008, 0x0410000C, 0x07100010 on 4 consecutive cycles with `busy_i`=0 → `valid_o` high for exactly 4 cycles starting 2 cycles after the last write, same words in order, groups_o back to 0.
- **Busy gating**: same group written with `busy_i`=1 → no `valid_o` while busy. Drop `busy_i` → the burst starts on the next cycle.
- **Back-to-back groups**: two groups written contiguously, `busy_i` tied 0 → two 4-cycle bursts separated by exactly 2 idle cycles.
- **Overflow and flush**: 17 writes with bit24=0 → 17th dropped, `overflow_o`=1, `ready_o`=0, fill_o=16, no output. Pulse `flush_i` → fill_o=0, `ready_o`=1, `overflow_o` stays 1.
- **Reset mid-burst**: assert `rst` during word 2 of a burst → `valid_o`=0 the next cycle, fill_o=0, groups_o=0; a subsequent group bursts normally.

Source files
------------

// File: rtl/ocra1_pkg.sv
// rtl/ocra1_pkg.sv - OCRA1 command word field constants and word buffer FSM states
package ocra1_pkg;

    localparam int OCRA1_WORD_W    = 32;
    localparam int OCRA1_CH_LSB    = 25;
    localparam int OCRA1_CH_W      = 2;
    localparam int OCRA1_UPD_BIT   = 24;
    localparam int OCRA1_PAYLOAD_W = 24;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_BURST = 1'b1
    } wb_state_e;

    // The update bit closes a group: the DAC outputs change together on it.
    function automatic logic is_terminator(input logic [OCRA1_WORD_W-1:0] word);
        return word[OCRA1_UPD_BIT];
    endfunction

endpackage

// File: rtl/ocra1_sync_fifo.sv
// rtl/ocra1_sync_fifo.sv - synchronous FIFO with flush, fill count and combinational head word
module ocra1_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   fill,
    output logic [WIDTH-1:0]      head
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign fill    = count;
    assign head    = mem[rd_ptr];

    // Fullness is judged on the count at the start of the cycle, so a
    // simultaneous pop never makes room for a write in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ocra1_word_buffer.sv
// rtl/ocra1_word_buffer.sv - elastic buffer releasing complete OCRA1 update groups as bursts
module ocra1_word_buffer
    import ocra1_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int HOLDOFF    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OCRA1_WORD_W-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    flush_i,
    input  logic                    busy_i,
    output logic [OCRA1_WORD_W-1:0] data_o,
    output logic                    valid_o,
    output logic [DEPTH_LOG2:0]     fill_o,
    output logic [DEPTH_LOG2:0]     groups_o,
    output logic                    overflow_o
);

    localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);

    wb_state_e               state;
    wb_state_e               state_nxt;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [HOLD_W-1:0]       hold_nxt;
    logic [DEPTH_LOG2:0]     groups;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DEPTH_LOG2:0]     fifo_fill;
    logic [OCRA1_WORD_W-1:0] head;
    logic                    push;
    logic                    pop;
    logic                    push_term;
    logic                    pop_term;

    assign push      = valid_i && !fifo_full && !flush_i;
    assign push_term = push && is_terminator(data_i);
    assign pop_term  = pop && is_terminator(head);

    assign ready_o   = !fifo_full && !rst;
    assign fill_o    = fifo_fill;
    assign groups_o  = groups;

    ocra1_sync_fifo #(
        .WIDTH      (OCRA1_WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_i),
        .push      (push),
        .push_data (data_i),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .fill      (fifo_fill),
        .head      (head)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            WB_IDLE: begin
                // A launch only happens with a whole group stored, so the
                // burst can run to its terminator without ever starving.
                if (groups != '0 && hold_cnt == '0 && !busy_i) begin
                    pop = 1'b1;
                    if (!is_terminator(head)) begin
                        state_nxt = WB_BURST;
                    end
                end
            end
            WB_BURST: begin
                pop = !fifo_empty;
                if (!fifo_empty && is_terminator(head)) begin
                    state_nxt = WB_IDLE;
                end
            end
            default: state_nxt = WB_IDLE;
        endcase
        if (flush_i) begin
            pop       = 1'b0;
            state_nxt = WB_IDLE;
        end
    end

    always_comb begin
        hold_nxt = hold_cnt;
        if (pop_term) begin
            hold_nxt = HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_nxt = hold_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state    <= WB_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            groups <= '0;
        end else begin
            case ({push_term, pop_term})
                2'b10:   groups <= groups + 1'b1;
                2'b01:   groups <= groups - 1'b1;
                default: groups <= groups;
            endcase
        end
    end

    // data_o keeps its last word between bursts and across a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= pop;
            if (pop) begin
                data_o <= head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (valid_i && fifo_full && !flush_i) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ocra1_word_buffer.sv
// tb/tb_ocra1_word_buffer.sv - directed and randomized self-checking bench for ocra1_word_buffer
module tb_ocra1_word_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        busy_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic [4:0]  fill_o;
    logic [4:0]  groups_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] grp_a [4] = '{32'h0010_0004, 32'h0210_0008, 32'h0410_000C, 32'h0710_0010};
    logic [31:0] grp_b [4] = '{32'h0200_0001, 32'h04FF_FFFF, 32'h0612_3456, 32'h0165_4321};

    logic [31:0] wr_w [32];
    int          wr_n;
    int          ex_off [32];
    logic [31:0] ex_w [32];
    int          ex_n;

    ocra1_word_buffer #(.DEPTH_LOG2(4), .HOLDOFF(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .flush_i    (flush_i),
        .busy_i     (busy_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .fill_o     (fill_o),
        .groups_o   (groups_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic plan_group(input int idx, input int off, input logic [31:0] w);
        ex_off[idx] = off;
        ex_w[idx]   = w;
    endtask

    // Called at a falling edge; drives wr_w and expects valid_o exactly at ex_off.
    task automatic watch(input string tag, input int ncyc);
        int k = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (i < wr_n) begin
                valid_i = 1'b1;
                data_i  = wr_w[i];
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
            if (k < ex_n && ex_off[k] == i + 1) begin
                check({tag, " valid"}, 32'(valid_o), 1);
                check({tag, " data"}, data_o, ex_w[k]);
                k++;
            end else begin
                check({tag, " idle"}, 32'(valid_o), 0);
            end
        end
        valid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_q [$];
        logic [31:0] grp_q [$];
        logic [31:0] w;
        logic [31:0] drove_word;
        int          fill_m;
        int          groups_m;
        int          idle_n;
        int          n;
        bit          drove;
        bit          in_burst;
        bit          busy_seen;

        // reset
        repeat (3) @(negedge clk);
        check("rst ready", 32'(ready_o), 0);
        check("rst valid", 32'(valid_o), 0);
        check("rst data", data_o, 0);
        check("rst fill", 32'(fill_o), 0);
        check("rst groups", 32'(groups_o), 0);
        check("rst overflow", 32'(overflow_o), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post rst ready", 32'(ready_o), 1);

        // single group
        for (int j = 0; j < 4; j++) begin
            wr_w[j] = grp_a[j];
            plan_group(j, 5 + j, grp_a[j]);
        end
        wr_n = 4;
        ex_n = 4;
        watch("single", 9);
        check("single groups", 32'(groups_o), 0);
        check("single fill", 32'(fill_o), 0);

        // busy gating
        busy_i = 1'b1;
        ex_n = 0;
        watch("busy hold", 8);
        check("busy groups", 32'(groups_o), 1);
        check("busy fill", 32'(fill_o), 4);
        busy_i = 1'b0;
        wr_n = 0;
        for (int j = 0; j < 4; j++) plan_group(j, 1 + j, grp_a[j]);
        ex_n = 4;
        watch("busy release", 5);

        // back-to-back groups: two idle cycles between bursts
        for (int j = 0; j < 4; j++) begin
            wr_w[j]     = grp_a[j];
            wr_w[j + 4] = grp_b[j];
            plan_group(j, 5 + j, grp_a[j]);
            plan_group(j + 4, 11 + j, grp_b[j]);
        end
        wr_n = 8;
        ex_n = 8;
        watch("b2b", 16);
        check("b2b groups", 32'(groups_o), 0);

        // write coinciding with flush is discarded
        flush_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'h0100_0000;
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush wr fill", 32'(fill_o), 0);
        check("flush wr groups", 32'(groups_o), 0);
        check("flush wr overflow", 32'(overflow_o), 0);

        // overflow and flush
        for (int i = 0; i < 17; i++) begin
            valid_i = 1'b1;
            data_i  = 32'h0000_0100 + i;
            @(negedge clk);
            check("ovf fill", 32'(fill_o), (i < 16) ? i + 1 : 16);
            check("ovf flag", 32'(overflow_o), (i == 16) ? 1 : 0);
            check("ovf valid", 32'(valid_o), 0);
        end
        valid_i = 1'b0;
        check("ovf ready", 32'(ready_o), 0);
        @(negedge clk);
        check("ovf hold fill", 32'(fill_o), 16);
        check("ovf hold valid", 32'(valid_o), 0);
        check("ovf groups", 32'(groups_o), 0);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush fill", 32'(fill_o), 0);
        check("flush ready", 32'(ready_o), 1);
        check("flush overflow sticky", 32'(overflow_o), 1);

        // reset during second word of a burst
        for (int j = 0; j < 4; j++) wr_w[j] = grp_a[j];
        wr_n = 4;
        plan_group(0, 5, grp_a[0]);
        plan_group(1, 6, grp_a[1]);
        ex_n = 2;
        watch("pre rst", 6);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst valid", 32'(valid_o), 0);
        check("mid rst fill", 32'(fill_o), 0);
        check("mid rst groups", 32'(groups_o), 0);
        check("mid rst ready", 32'(ready_o), 0);
        rst = 1'b0;
        @(negedge clk);
        check("after rst ready", 32'(ready_o), 1);
        check("after rst overflow", 32'(overflow_o), 0);
        for (int j = 0; j < 4; j++) plan_group(j, 5 + j, grp_b[j]);
        for (int j = 0; j < 4; j++) wr_w[j] = grp_b[j];
        ex_n = 4;
        watch("after rst", 9);

        // randomized groups against an ordered-queue model
        repeat (3) @(negedge clk);
        fill_m   = 0;
        groups_m = 0;
        idle_n   = 99;
        in_burst = 1'b0;
        drove    = 1'b0;
        drove_word = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            busy_seen = busy_i;
            @(negedge clk);
            if (drove) begin
                exp_q.push_back(drove_word);
                fill_m++;
                if (drove_word[24]) groups_m++;
            end
            if (in_burst) check("rnd burst continuity", 32'(valid_o), 1);
            if (valid_o) begin
                if (!in_burst) begin
                    check("rnd busy gate", 32'(busy_seen), 0);
                    check("rnd holdoff gap", 32'(idle_n >= 2), 1);
                end
                if (exp_q.size() == 0) begin
                    check("rnd spurious word", 32'(valid_o), 0);
                end else begin
                    w = exp_q.pop_front();
                    check("rnd data", data_o, w);
                    fill_m--;
                    if (w[24]) groups_m--;
                end
                in_burst = !data_o[24];
                idle_n   = 0;
            end else begin
                idle_n++;
            end
            check("rnd fill", 32'(fill_o), fill_m);
            check("rnd groups", 32'(groups_o), groups_m);

            busy_i = (cyc < 2500) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (grp_q.size() == 0 && cyc < 2400) begin
                n = $urandom_range(1, 5);
                for (int j = 0; j < n; j++) begin
                    grp_q.push_back({5'b0, 2'($urandom), (j == n - 1), 24'($urandom)});
                end
            end
            drove = 1'b0;
            if (grp_q.size() > 0 && $urandom_range(0, 2) != 0 && ready_o) begin
                valid_i    = 1'b1;
                data_i     = grp_q.pop_front();
                drove      = 1'b1;
                drove_word = data_i;
            end else begin
                valid_i = 1'b0;
            end
        end
        valid_i = 1'b0;
        check("rnd drained", 32'(exp_q.size()), 0);
        check("rnd pending writes", 32'(grp_q.size()), 0);
        check("rnd overflow", 32'(overflow_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
